// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the handshaked data memory: access modes,
// FSM states, captured-request payload and lane helpers.
package data_mem_pkg;

   localparam int unsigned MODE_W = 2;

   localparam logic [MODE_W-1:0] MODE_BYTE = 2'b00;
   localparam logic [MODE_W-1:0] MODE_HALF = 2'b01;
   localparam logic [MODE_W-1:0] MODE_WORD = 2'b10;
   localparam logic [MODE_W-1:0] MODE_RSVD = 2'b11;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   // Request fields kept for the response phase; the word index is held separately
   typedef struct packed {
      logic              we;
      logic [MODE_W-1:0] mode;
      logic              sgn;
      logic [1:0]        lane;
   } req_t;

   function automatic logic access_err(input logic [MODE_W-1:0] mode, input logic [1:0] lane);
      case (mode)
         MODE_BYTE: access_err = 1'b0;
         MODE_HALF: access_err = lane[0];
         MODE_WORD: access_err = (lane != 2'b00);
         default:   access_err = 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [MODE_W-1:0] mode, input logic [1:0] lane);
      case (mode)
         MODE_BYTE: store_be = 4'(4'b0001 << lane);
         MODE_HALF: store_be = lane[1] ? 4'b1100 : 4'b0011;
         MODE_WORD: store_be = 4'b1111;
         default:   store_be = 4'b0000;
      endcase
   endfunction

   // Replicate right-aligned store data so every candidate lane sees it
   function automatic logic [31:0] store_data(input logic [MODE_W-1:0] mode, input logic [31:0] wdata);
      case (mode)
         MODE_BYTE: store_data = {4{wdata[7:0]}};
         MODE_HALF: store_data = {2{wdata[15:0]}};
         default:   store_data = wdata;
      endcase
   endfunction

endpackage

// File: rtl/data_mem_hs_if.sv
// Request/response handshake bundle between a memory client and data_mem_hs.
interface data_mem_hs_if #(
   parameter int unsigned ADDR_WIDTH = 12
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [1:0]            req_mode;
   logic                  req_signed;
   logic [31:0]           req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [31:0]           rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_mode, req_signed, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_mode, req_signed, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/data_mem_fmt.sv
// Load formatter: picks the addressed byte/half/word and sign- or zero-extends it.
module data_mem_fmt
   import data_mem_pkg::*;
(
   input  logic [31:0]       word,
   input  logic [1:0]        addr,
   input  logic [MODE_W-1:0] mode,
   input  logic              sign_ext,
   output logic [31:0]       data,
   output logic              err
);

   logic [7:0]  byte_c;
   logic [15:0] half_c;

   always_comb begin
      byte_c = word[7:0];
      case (addr)
         2'd0:    byte_c = word[7:0];
         2'd1:    byte_c = word[15:8];
         2'd2:    byte_c = word[23:16];
         default: byte_c = word[31:24];
      endcase
      half_c = addr[1] ? word[31:16] : word[15:0];
      err    = access_err(mode, addr);
      data   = '0;
      if (!err) begin
         case (mode)
            MODE_BYTE: data = {{24{sign_ext & byte_c[7]}}, byte_c};
            MODE_HALF: data = {{16{sign_ext & half_c[15]}}, half_c};
            MODE_WORD: data = word;
            default:   data = '0;
         endcase
      end
   end

endmodule

// File: rtl/data_mem_hs.sv
// Word-organised data memory with byte/half/word access, valid/ready handshake,
// fixed extra latency per access and a word-per-cycle clear engine.
module data_mem_hs
   import data_mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 12,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned INIT_CLEAR  = 1
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         clear_start,
   output logic         busy,
   data_mem_hs_if.slave bus
);

   localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
   localparam int unsigned DEPTH  = 2 ** IDX_W;
   localparam int unsigned WCNT_W = 4;
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DEPTH - 1);
   localparam logic [WCNT_W-1:0] WAIT_LAST = (WAIT_CYCLES == 0) ? '0 : WCNT_W'(WAIT_CYCLES - 1);

   state_e              state_q, state_d;
   logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [IDX_W-1:0]    clr_idx_q, clr_idx_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   req_t                req_q, req_d;
   logic                req_ready_q, req_ready_d;
   logic                busy_q, busy_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_err_q, rsp_err_d;
   logic [31:0]         rsp_rdata_q, rsp_rdata_d;

   logic [31:0]         mem_q [DEPTH];
   logic                mem_we_c;
   logic [IDX_W-1:0]    mem_idx_c;
   logic [31:0]         mem_wdata_c;
   logic [3:0]          mem_be_c;
   logic [31:0]         fmt_data;
   logic                fmt_err;

   data_mem_fmt u_fmt (
      .word     (mem_q[idx_q]),
      .addr     (req_q.lane),
      .mode     (req_q.mode),
      .sign_ext (req_q.sgn),
      .data     (fmt_data),
      .err      (fmt_err)
   );

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      clr_idx_d   = clr_idx_q;
      idx_d       = idx_q;
      req_d       = req_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      mem_we_c    = 1'b0;
      mem_idx_c   = bus.req_addr[ADDR_WIDTH-1:2];
      mem_wdata_c = store_data(bus.req_mode, bus.req_wdata);
      mem_be_c    = store_be(bus.req_mode, bus.req_addr[1:0]);

      case (state_q)
         IDLE: begin
            // req_ready_q is low in IDLE only on the first cycle after reset
            if (!req_ready_q) begin
               state_d   = (INIT_CLEAR != 0) ? CLEAR : IDLE;
               clr_idx_d = '0;
            end else if (clear_start) begin
               state_d   = CLEAR;
               clr_idx_d = '0;
            end else if (bus.req_valid) begin
               req_d      = '{we: bus.req_we, mode: bus.req_mode, sgn: bus.req_signed,
                              lane: bus.req_addr[1:0]};
               idx_d      = bus.req_addr[ADDR_WIDTH-1:2];
               wait_cnt_d = '0;
               mem_we_c   = bus.req_we && !access_err(bus.req_mode, bus.req_addr[1:0]);
               state_d    = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
         end
         CLEAR: begin
            mem_we_c    = 1'b1;
            mem_idx_c   = clr_idx_q;
            mem_wdata_c = '0;
            mem_be_c    = 4'b1111;
            if (clr_idx_q == IDX_LAST) begin
               state_d = IDLE;
            end else begin
               clr_idx_d = clr_idx_q + 1'b1;
            end
         end
         WAIT: begin
            if (wait_cnt_q == WAIT_LAST) begin
               state_d = RESP;
            end else begin
               wait_cnt_d = wait_cnt_q + 4'd1;
            end
         end
         RESP: begin
            // First RESP cycle reads and formats; the response then holds until taken
            if (!rsp_valid_q) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = fmt_err;
               rsp_rdata_d = req_q.we ? '0 : fmt_data;
            end else if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = '0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      req_ready_d = (state_d == IDLE);
      busy_d      = (state_d == CLEAR);
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         clr_idx_q   <= '0;
         idx_q       <= '0;
         req_q       <= '0;
         req_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         clr_idx_q   <= clr_idx_d;
         idx_q       <= idx_d;
         req_q       <= req_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Byte-lane write port shared by stores and the clear engine
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_be_c[b]) begin
               mem_q[mem_idx_c][8*b +: 8] <= mem_wdata_c[8*b +: 8];
            end
         end
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_data_mem_hs.sv
// Directed bench for data_mem_hs (ADDR_WIDTH=6, WAIT_CYCLES=3, INIT_CLEAR=1).
module tb_data_mem_hs;
   import data_mem_pkg::*;

   logic clk;
   logic clr_n;
   logic clear_start;
   logic busy;
   int   total;
   int   bad;

   data_mem_hs_if #(.ADDR_WIDTH(6)) bus ();

   data_mem_hs #(
      .ADDR_WIDTH  (6),
      .WAIT_CYCLES (3),
      .INIT_CLEAR  (1)
   ) dut (
      .clk         (clk),
      .clr_n       (clr_n),
      .clear_start (clear_start),
      .busy        (busy),
      .bus         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // Called on a cycle where the clear has just been triggered or reset released
   task automatic wait_clear(input string tag);
      int n    = 0;
      int seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.rsp_valid === 1'b1) seen++;
         if (busy === 1'b1) n++;
         if (bus.req_ready === 1'b1) break;
      end
      chk({tag, "_busy_cycles"}, 32'(n), 32'd16);
      chk({tag, "_no_rsp"}, 32'(seen), 32'd0);
      chk({tag, "_ready"}, 32'({bus.req_ready, busy}), 32'b10);
   endtask

   // One full transaction: issue, measure latency, hold rsp_ready low, consume
   task automatic txn(input string tag, input logic we, input logic [5:0] addr,
                      input logic [1:0] mode, input logic sgn, input logic [31:0] wdata,
                      input int hold, input bit poke,
                      input logic [31:0] exp_data, input logic exp_err);
      logic [31:0] d0;
      int          lat;
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_addr   = addr;
      bus.req_mode   = mode;
      bus.req_signed = sgn;
      bus.req_wdata  = wdata;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      clear_start   = poke;
      lat = 0;
      while (bus.rsp_valid !== 1'b1 && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      clear_start = 1'b0;
      chk({tag, "_lat"}, 32'(lat), 32'd4);
      chk({tag, "_data"}, bus.rsp_rdata, exp_data);
      chk({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
      d0 = bus.rsp_rdata;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
         chk({tag, "_hold_data"}, bus.rsp_rdata, d0);
         chk({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      chk({tag, "_done"}, 32'({bus.rsp_valid, bus.req_ready, busy}), 32'b010);
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      clr_n          = 1'b0;
      clear_start    = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_addr   = '0;
      bus.req_mode   = MODE_WORD;
      bus.req_signed = 1'b0;
      bus.req_wdata  = '0;
      bus.rsp_ready  = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      clr_n = 1'b1;
      wait_clear("init");

      txn("ldw3c",   1'b0, 6'h3C, MODE_WORD, 1'b0, 32'h0,        0, 1'b0, 32'h00000000, 1'b0);
      txn("stw10",   1'b1, 6'h10, MODE_WORD, 1'b0, 32'h8899AABB, 0, 1'b0, 32'h00000000, 1'b0);
      txn("ldb13s",  1'b0, 6'h13, MODE_BYTE, 1'b1, 32'h0,        0, 1'b0, 32'hFFFFFF88, 1'b0);
      txn("ldb13u",  1'b0, 6'h13, MODE_BYTE, 1'b0, 32'h0,        0, 1'b0, 32'h00000088, 1'b0);
      txn("ldh10s",  1'b0, 6'h10, MODE_HALF, 1'b1, 32'h0,        0, 1'b0, 32'hFFFFAABB, 1'b0);
      txn("ldh12u",  1'b0, 6'h12, MODE_HALF, 1'b0, 32'h0,        0, 1'b0, 32'h00008899, 1'b0);
      txn("ldb10s",  1'b0, 6'h10, MODE_BYTE, 1'b1, 32'h0,        0, 1'b0, 32'hFFFFFFBB, 1'b0);
      txn("ldb11u_poke", 1'b0, 6'h11, MODE_BYTE, 1'b0, 32'h0,    0, 1'b1, 32'h000000AA, 1'b0);
      txn("sth12",   1'b1, 6'h12, MODE_HALF, 1'b0, 32'h00001234, 0, 1'b0, 32'h00000000, 1'b0);
      txn("ldw10a",  1'b0, 6'h10, MODE_WORD, 1'b0, 32'h0,        0, 1'b0, 32'h1234AABB, 1'b0);
      txn("stb10",   1'b1, 6'h10, MODE_BYTE, 1'b0, 32'hFFFFFF5A, 0, 1'b0, 32'h00000000, 1'b0);
      txn("ldw10b",  1'b0, 6'h10, MODE_WORD, 1'b0, 32'h0,        0, 1'b0, 32'h1234AA5A, 1'b0);

      txn("ldw11_err", 1'b0, 6'h11, MODE_WORD, 1'b0, 32'h0,        0, 1'b0, 32'h0, 1'b1);
      txn("sth13_err", 1'b1, 6'h13, MODE_HALF, 1'b0, 32'hDEADBEEF, 0, 1'b0, 32'h0, 1'b1);
      txn("rsvd_err",  1'b1, 6'h10, MODE_RSVD, 1'b0, 32'hFFFFFFFF, 0, 1'b0, 32'h0, 1'b1);
      txn("ldh11_err", 1'b0, 6'h11, MODE_HALF, 1'b1, 32'h0,        0, 1'b0, 32'h0, 1'b1);
      txn("ldw10_hold", 1'b0, 6'h10, MODE_WORD, 1'b0, 32'h0,       5, 1'b0, 32'h1234AA5A, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("one_rsp_only", 32'({bus.rsp_valid, bus.req_ready}), 32'b01);

      // Explicit clear from IDLE
      txn("stw3c", 1'b1, 6'h3C, MODE_WORD, 1'b0, 32'hCAFEF00D, 0, 1'b0, 32'h0, 1'b0);
      clear_start = 1'b1;
      @(posedge clk);
      #1;
      clear_start = 1'b0;
      wait_clear("clr");
      txn("clr_ld3c", 1'b0, 6'h3C, MODE_WORD, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0);
      txn("clr_ld10", 1'b0, 6'h10, MODE_WORD, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0);

      // Reset in the middle of a clear restarts it from index 0
      txn("stw3c_b", 1'b1, 6'h3C, MODE_WORD, 1'b0, 32'h11223344, 0, 1'b0, 32'h0, 1'b0);
      clear_start = 1'b1;
      @(posedge clk);
      #1;
      clear_start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      clr_n = 1'b0;
      #1;
      chk("midclr_rst_out", 32'({bus.rsp_valid, bus.req_ready, busy}), 32'b000);
      @(negedge clk);
      clr_n = 1'b1;
      wait_clear("midclr");
      txn("midclr_ld3c", 1'b0, 6'h3C, MODE_WORD, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0);

      // Reset during WAIT drops the pending load
      txn("stw10_c", 1'b1, 6'h10, MODE_WORD, 1'b0, 32'hA5A5A5A5, 0, 1'b0, 32'h0, 1'b0);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 6'h10;
      bus.req_mode  = MODE_WORD;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      clr_n = 1'b0;
      #1;
      chk("midwait_rst_out", 32'({bus.rsp_valid, bus.req_ready, busy}), 32'b000);
      chk("midwait_rst_rdata", bus.rsp_rdata, 32'h0);
      @(negedge clk);
      clr_n = 1'b1;
      wait_clear("midwait");
      txn("midwait_ld10", 1'b0, 6'h10, MODE_WORD, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
